// File: rtl/min_isa_pkg.sv
// Shared MIN ISA definitions: instruction fields, EU control word layout,
// sequencer state encoding and the per-state control word table.
package min_isa_pkg;

  localparam int ISA_IW   = 16;
  localparam int EU_CW_W  = 18;

  // Instruction class field ifd[12:10]
  localparam logic [2:0] OPC_LD  = 3'b001;
  localparam logic [2:0] OPC_ST  = 3'b010;
  localparam logic [2:0] OPC_BR  = 3'b011;
  localparam logic [2:0] OPC_ALU = 3'b100;

  // Addressing mode field ifd[5:4]
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IND = 2'b01;
  localparam logic [1:0] MODE_IDX = 2'b10;

  // EU alu field codes that update the condition flags
  localparam logic [2:0] ALU_OP  = 3'b110;
  localparam logic [2:0] ALU_FLG = 3'b100;

  typedef enum logic [2:0] {
    IC_HALT, IC_LD, IC_ST, IC_BR, IC_ALU, IC_ILL
  } iclass_t;

  typedef enum logic [4:0] {
    ST_RST, ST_FETCH, ST_DISP, ST_LDI_RD, ST_LD_WB, ST_IDX_D, ST_IDX_P,
    ST_IDX_A, ST_LDX_RD, ST_STI_WR, ST_STX_WR, ST_ALU_EX, ST_ALU_WB,
    ST_BR_TK, ST_BR_NT, ST_HALT, ST_ERR
  } state_t;

  typedef struct packed {
    logic [2:0] asrc;
    logic [1:0] adest;
    logic [2:0] bsrc;
    logic [2:0] bdest;
    logic [2:0] alu;
    logic [2:0] mem;
    logic       ldire;
  } eu_cw_t;

  // Moore control word emitted while the sequencer sits in state s.
  function automatic eu_cw_t cw_of(input state_t s);
    eu_cw_t cw;
    cw = '0;
    case (s)
      ST_FETCH:  cw = '{3'b011, 2'b00, 3'b000, 3'b000, 3'b001, 3'b010, 1'b0};
      ST_DISP:   cw = '{3'b101, 2'b11, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
      ST_LDI_RD: cw = '{3'b010, 2'b00, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0};
      ST_LD_WB:  cw = '{3'b011, 2'b00, 3'b111, 3'b001, 3'b001, 3'b010, 1'b0};
      ST_IDX_D:  cw = '{3'b011, 2'b00, 3'b000, 3'b000, 3'b001, 3'b001, 1'b0};
      ST_IDX_P:  cw = '{3'b101, 2'b11, 3'b111, 3'b100, 3'b000, 3'b000, 1'b0};
      ST_IDX_A:  cw = '{3'b010, 2'b00, 3'b110, 3'b000, 3'b010, 3'b000, 1'b0};
      ST_LDX_RD: cw = '{3'b101, 2'b00, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0};
      ST_STI_WR: cw = '{3'b001, 2'b00, 3'b010, 3'b000, 3'b000, 3'b111, 1'b0};
      ST_STX_WR: cw = '{3'b001, 2'b00, 3'b101, 3'b000, 3'b000, 3'b111, 1'b0};
      ST_ALU_EX: cw = '{3'b001, 2'b00, 3'b010, 3'b000, 3'b110, 3'b000, 1'b0};
      ST_ALU_WB: cw = '{3'b011, 2'b00, 3'b101, 3'b001, 3'b001, 3'b010, 1'b0};
      ST_BR_TK:  cw = '{3'b000, 2'b00, 3'b111, 3'b011, 3'b000, 3'b000, 1'b0};
      ST_BR_NT:  cw = '{3'b101, 2'b11, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
      default:   cw = '0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/min_idec.sv
// Combinational instruction decoder: classifies the prefetched word ifd.
module min_idec
  import min_isa_pkg::*;
(
  input  logic [ISA_IW-1:0] ifd,
  output iclass_t           iclass,
  output logic [1:0]        mode,
  output logic              illegal
);

  logic [2:0] top;
  logic [2:0] opc;

  assign top  = ifd[15:13];
  assign opc  = ifd[12:10];
  assign mode = ifd[5:4];

  // NOTE: iclass gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    iclass = IC_ILL;
    if (ifd == '0) begin
      iclass = IC_HALT;
    end else if (top == 3'b000) begin
      case (opc)
        OPC_LD: if (mode == MODE_IND || mode == MODE_IDX) iclass = IC_LD;
        OPC_ST: if (mode == MODE_IND || mode == MODE_IDX) iclass = IC_ST;
        OPC_BR: iclass = IC_BR;
        default: iclass = IC_ILL;
      endcase
    end else if (!top[2] && opc == OPC_ALU && mode == MODE_REG) begin
      iclass = IC_ALU;
    end
  end

  assign illegal = (iclass == IC_ILL);

endmodule

// File: rtl/min_ctrl_seq.sv
// Hardwired MIN microsequencer: FSM, condition flags, latched instruction
// and registered Moore control outputs for the execution unit.
module min_ctrl_seq
  import min_isa_pkg::*;
#(
  parameter int CW_W  = 18,
  parameter int IW    = 16,
  parameter bit TRACE = 1'b0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [IW-1:0]   ifd,
  input  logic [3:0]      cc,
  output logic [CW_W-1:0] eucntl,
  output logic [2:0]      opcntl,
  output logic            halted,
  output logic            illegal
);

  state_t     state, state_d;
  iclass_t    dec_class;
  logic [1:0] dec_mode;
  logic       dec_illegal;
  logic [3:0] flags;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0] cond;
  logic       br_taken;
  eu_cw_t     cw_d;
  logic [2:0] opcntl_d;

  min_idec u_idec (
    .ifd     (ifd),
    .iclass  (dec_class),
    .mode    (dec_mode),
    .illegal (dec_illegal)
  );

  // Branch condition comes from the instruction latched at dispatch.
  assign cond     = ir_q[9:6];
  assign br_taken = (cond == 4'b0000) || (|(cond & flags));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_RST;
      eucntl  <= '0;
      opcntl  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      flags   <= '0;
      ir_q    <= '0;
    end else begin
      state   <= state_d;
      eucntl  <= CW_W'(cw_d);
      opcntl  <= opcntl_d;
      halted  <= halted  | (state_d == ST_HALT);
      illegal <= illegal | (state_d == ST_ERR);
      if (eucntl[6:4] == ALU_OP || eucntl[6:4] == ALU_FLG)
        flags <= cc;
      if (state == ST_DISP)
        ir_q <= ifd;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: state_d = ST_DISP;
      ST_DISP: begin
        if (dec_illegal) begin
          state_d = ST_ERR;
        end else begin
          case (dec_class)
            IC_HALT: state_d = ST_HALT;
            IC_LD:   state_d = (dec_mode == MODE_IND) ? ST_LDI_RD : ST_IDX_D;
            IC_ST:   state_d = (dec_mode == MODE_IND) ? ST_STI_WR : ST_IDX_D;
            IC_BR:   state_d = ST_IDX_D;
            IC_ALU:  state_d = ST_ALU_EX;
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_IDX_D: begin
        if (ir_q[12:10] == OPC_BR)
          state_d = br_taken ? ST_BR_TK : ST_BR_NT;
        else
          state_d = ST_IDX_P;
      end
      ST_IDX_P:  state_d = ST_IDX_A;
      ST_IDX_A:  state_d = (ir_q[12:10] == OPC_LD) ? ST_LDX_RD : ST_STX_WR;
      ST_LDI_RD, ST_LDX_RD: state_d = ST_LD_WB;
      ST_ALU_EX: state_d = ST_ALU_WB;
      ST_LD_WB, ST_ALU_WB:  state_d = ST_DISP;
      ST_STI_WR, ST_STX_WR, ST_BR_TK, ST_BR_NT: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase
  end

  // Outputs are decoded from the next state and registered above, so the
  // ALU op must come from ifd when it is being latched on the same edge.
  always_comb begin
    ir_d     = (state == ST_DISP) ? ifd : ir_q;
    cw_d     = cw_of(state_d);
    opcntl_d = (state_d == ST_ALU_EX) ? ir_d[15:13] : 3'b000;
  end

  // Simulation-only consistency checks between sticky flags and state.
  if (TRACE) begin : g_trace
    always_ff @(posedge clock) begin
      if (reset_n) begin
        assert (halted == (state == ST_HALT));
        assert (illegal == (state == ST_ERR));
      end
    end
  end

endmodule

// File: tb/tb_min_ctrl_seq.sv
// Directed self-checking bench for the MIN microsequencer.
module tb_min_ctrl_seq;

  logic        clock;
  logic        reset_n;
  logic [15:0] ifd;
  logic [3:0]  cc;
  logic [17:0] eucntl;
  logic [2:0]  opcntl;
  logic        halted;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] W_ZERO   = 18'b000_00_000_000_000_000_0;
  localparam logic [17:0] W_FETCH  = 18'b011_00_000_000_001_010_0;
  localparam logic [17:0] W_DISP   = 18'b101_11_000_000_000_000_1;
  localparam logic [17:0] W_LDI_RD = 18'b010_00_000_000_000_001_0;
  localparam logic [17:0] W_LD_WB  = 18'b011_00_111_001_001_010_0;
  localparam logic [17:0] W_IDX_D  = 18'b011_00_000_000_001_001_0;
  localparam logic [17:0] W_IDX_P  = 18'b101_11_111_100_000_000_0;
  localparam logic [17:0] W_IDX_A  = 18'b010_00_110_000_010_000_0;
  localparam logic [17:0] W_LDX_RD = 18'b101_00_000_000_000_001_0;
  localparam logic [17:0] W_STI_WR = 18'b001_00_010_000_000_111_0;
  localparam logic [17:0] W_STX_WR = 18'b001_00_101_000_000_111_0;
  localparam logic [17:0] W_ALU_EX = 18'b001_00_010_000_110_000_0;
  localparam logic [17:0] W_ALU_WB = 18'b011_00_101_001_001_010_0;
  localparam logic [17:0] W_BR_TK  = 18'b000_00_111_011_000_000_0;
  localparam logic [17:0] W_BR_NT  = 18'b101_11_000_000_000_000_0;

  localparam logic [15:0] I_LDI = 16'b000_001_0001_01_0111;
  localparam logic [15:0] I_LDX = 16'b000_001_0010_10_0011;
  localparam logic [15:0] I_STI = 16'b000_010_0000_01_0001;
  localparam logic [15:0] I_STX = 16'b000_010_0000_10_0100;
  localparam logic [15:0] I_ADD = 16'b001_100_0001_00_0010;

  min_ctrl_seq #(.CW_W(18), .IW(16), .TRACE(1'b0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ifd     (ifd),
    .cc      (cc),
    .eucntl  (eucntl),
    .opcntl  (opcntl),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Resets and walks to the DISP cycle; stimulus only.
  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifd = I_LDI;
    cc = 4'b0000;
    #22;
    checks++;
    if ({eucntl, opcntl, halted, illegal} !== {W_ZERO, 3'b000, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs: got eucntl=%b opcntl=%b halted=%b illegal=%b, want all zero",
               eucntl, opcntl, halted, illegal);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (eucntl !== W_ZERO) begin
      errors++;
      $display("FAIL reset_release_pre_edge: got %b want %b", eucntl, W_ZERO);
    end
    step();
    checks++;
    if (eucntl !== W_FETCH) begin
      errors++;
      $display("FAIL reset_first_fetch: got %b want %b", eucntl, W_FETCH);
    end
    step();
    checks++;
    if (eucntl !== W_DISP) begin
      errors++;
      $display("FAIL reset_first_disp: got %b want %b", eucntl, W_DISP);
    end
  endtask

  task automatic test_ld_indirect();
    logic [17:0] exp_w [3];
    exp_w = '{W_LDI_RD, W_LD_WB, W_DISP};
    ifd = I_LDI;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (eucntl !== exp_w[i] || opcntl !== 3'b000) begin
        errors++;
        $display("FAIL ld_ind[%0d]: got %b/%b want %b/000", i, eucntl, opcntl, exp_w[i]);
      end
    end
  endtask

  task automatic test_ld_indexed();
    logic [17:0] exp_w [6];
    exp_w = '{W_IDX_D, W_IDX_P, W_IDX_A, W_LDX_RD, W_LD_WB, W_DISP};
    ifd = I_LDX;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (eucntl !== exp_w[i]) begin
        errors++;
        $display("FAIL ld_idx[%0d]: got %b want %b", i, eucntl, exp_w[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [17:0] exp_i [3];
    logic [17:0] exp_x [6];
    exp_i = '{W_STI_WR, W_FETCH, W_DISP};
    exp_x = '{W_IDX_D, W_IDX_P, W_IDX_A, W_STX_WR, W_FETCH, W_DISP};
    ifd = I_STI;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (eucntl !== exp_i[i]) begin
        errors++;
        $display("FAIL st_ind[%0d]: got %b want %b", i, eucntl, exp_i[i]);
      end
    end
    ifd = I_STX;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (eucntl !== exp_x[i]) begin
        errors++;
        $display("FAIL st_idx[%0d]: got %b want %b", i, eucntl, exp_x[i]);
      end
    end
  endtask

  task automatic test_alu();
    logic [2:0] ops [3];
    ops = '{3'b001, 3'b010, 3'b011};
    for (int k = 0; k < 3; k++) begin
      ifd = {ops[k], 13'b100_0001_00_0010};
      step();
      checks++;
      if (eucntl !== W_ALU_EX || opcntl !== ops[k]) begin
        errors++;
        $display("FAIL alu_ex[%0d]: got %b/%b want %b/%b", k, eucntl, opcntl, W_ALU_EX, ops[k]);
      end
      step();
      checks++;
      if (eucntl !== W_ALU_WB || opcntl !== 3'b000) begin
        errors++;
        $display("FAIL alu_wb[%0d]: got %b/%b want %b/000", k, eucntl, opcntl, W_ALU_WB);
      end
      step();
      checks++;
      if (eucntl !== W_DISP) begin
        errors++;
        $display("FAIL alu_disp[%0d]: got %b want %b", k, eucntl, W_DISP);
      end
    end
  endtask

  // Each row: flags produced by an ALU op, branch cond, expected decision.
  task automatic test_branch();
    logic [3:0]  alu_cc [5];
    logic [3:0]  conds  [5];
    logic [17:0] exp_br [5];
    alu_cc = '{4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b1010};
    conds  = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b1000};
    exp_br = '{W_BR_TK, W_BR_NT, W_BR_TK, W_BR_NT, W_BR_TK};
    for (int k = 0; k < 5; k++) begin
      ifd = I_ADD;
      cc = alu_cc[k];
      step();
      step();
      cc = ~alu_cc[k];
      step();
      ifd = {6'b000_011, conds[k], 6'b00_0000};
      step();
      checks++;
      if (eucntl !== W_IDX_D) begin
        errors++;
        $display("FAIL br_idx_d[%0d]: got %b want %b", k, eucntl, W_IDX_D);
      end
      step();
      checks++;
      if (eucntl !== exp_br[k]) begin
        errors++;
        $display("FAIL br_decide[%0d]: got %b want %b", k, eucntl, exp_br[k]);
      end
      step();
      step();
      checks++;
      if (eucntl !== W_DISP) begin
        errors++;
        $display("FAIL br_return[%0d]: got %b want %b", k, eucntl, W_DISP);
      end
    end
    cc = 4'b0000;
  endtask

  task automatic test_illegal();
    logic [15:0] bad [3];
    bad = '{16'hE000, 16'b001_100_0001_01_0010, 16'b000_001_0000_11_0000};
    for (int k = 0; k < 3; k++) begin
      ifd = bad[k];
      step();
      checks++;
      if (eucntl !== W_ZERO || illegal !== 1'b1 || halted !== 1'b0) begin
        errors++;
        $display("FAIL illegal[%0d]: got eucntl=%b illegal=%b halted=%b want 0/1/0",
                 k, eucntl, illegal, halted);
      end
      ifd = I_LDI;
      step();
      step();
      checks++;
      if (eucntl !== W_ZERO || illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_stuck[%0d]: got eucntl=%b illegal=%b", k, eucntl, illegal);
      end
      do_reset();
      checks++;
      if (illegal !== 1'b0 || eucntl !== W_DISP) begin
        errors++;
        $display("FAIL illegal_clear[%0d]: got illegal=%b eucntl=%b", k, illegal, eucntl);
      end
    end
  endtask

  task automatic test_halt();
    ifd = 16'h0000;
    step();
    checks++;
    if (eucntl !== W_ZERO || halted !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL halt: got eucntl=%b halted=%b illegal=%b want 0/1/0", eucntl, halted, illegal);
    end
    ifd = I_LDI;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (eucntl !== W_ZERO || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_stuck: got eucntl=%b halted=%b", eucntl, halted);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || eucntl !== W_DISP) begin
      errors++;
      $display("FAIL halt_clear: got halted=%b eucntl=%b", halted, eucntl);
    end
  endtask

  task automatic test_reset_mid();
    ifd = I_LDX;
    step();
    step();
    step();
    checks++;
    if (eucntl !== W_IDX_A) begin
      errors++;
      $display("FAIL mid_reach_idx_a: got %b want %b", eucntl, W_IDX_A);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (eucntl !== W_ZERO || opcntl !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_immediate: got %b/%b want zero", eucntl, opcntl);
    end
    #2;
    reset_n = 1'b1;
    step();
    checks++;
    if (eucntl !== W_FETCH) begin
      errors++;
      $display("FAIL mid_restart_fetch: got %b want %b", eucntl, W_FETCH);
    end
    step();
    checks++;
    if (eucntl !== W_DISP) begin
      errors++;
      $display("FAIL mid_restart_disp: got %b want %b", eucntl, W_DISP);
    end
  endtask

  initial begin
    test_reset();
    test_ld_indirect();
    test_alu();
    test_ld_indexed();
    test_store();
    test_branch();
    test_illegal();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
